// File: rtl/cntry_car_detect.sv
// rtl/cntry_car_detect.sv - country-road vehicle detector: sensor debounce and queued-car count

module cntry_car_debounce #(
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic clock,
    input  logic clear,
    input  logic raw,
    output logic evt
);

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        RISE_CHK = 2'd1,
        HIGH     = 2'd2,
        FALL_CHK = 2'd3
    } db_state_t;

    localparam logic [3:0] DLOAD = 4'(DEBOUNCE - 1);

    logic      s1;
    logic      s2;
    db_state_t state;
    db_state_t next_state;
    logic [3:0] dcnt;
    logic [3:0] next_dcnt;
    logic      rise;

    always_ff @(posedge clock) begin
        if (clear) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= LOW;
            dcnt  <= 4'd0;
            evt   <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            state <= next_state;
            dcnt  <= next_dcnt;
            // Registering the rise keeps the counter one edge behind the debounced level.
            evt   <= rise;
        end
    end

    always_comb begin
        next_state = state;
        next_dcnt  = dcnt;
        rise       = 1'b0;
        case (state)
            LOW: begin
                if (s2) begin
                    if (DEBOUNCE == 1) begin
                        next_state = HIGH;
                        rise       = 1'b1;
                    end else begin
                        next_state = RISE_CHK;
                        next_dcnt  = DLOAD;
                    end
                end
            end
            RISE_CHK: begin
                if (!s2) begin
                    next_state = LOW;
                end else if (dcnt == 4'd1) begin
                    next_state = HIGH;
                    rise       = 1'b1;
                end else begin
                    next_dcnt = dcnt - 4'd1;
                end
            end
            HIGH: begin
                if (!s2) begin
                    if (DEBOUNCE == 1) begin
                        next_state = LOW;
                    end else begin
                        next_state = FALL_CHK;
                        next_dcnt  = DLOAD;
                    end
                end
            end
            FALL_CHK: begin
                if (s2) begin
                    next_state = HIGH;
                end else if (dcnt == 4'd1) begin
                    next_state = LOW;
                end else begin
                    next_dcnt = dcnt - 4'd1;
                end
            end
            default: begin
                next_state = LOW;
            end
        endcase
    end

endmodule

module cntry_car_detect #(
    parameter int unsigned DEBOUNCE = 3,
    parameter int unsigned MAX_CARS = 15,
    parameter int unsigned CW       = 4
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          arrive_raw,
    input  logic          depart_raw,
    input  logic [1:0]    cntry_sig,
    output logic          car_on_cntry_rd,
    output logic [CW-1:0] car_count,
    output logic          overflow,
    output logic          red_run
);

    localparam logic [CW-1:0] MAX_COUNT = CW'(MAX_CARS);

    logic arr_evt;
    logic dep_evt;
    logic sig_red;

    cntry_car_debounce #(.DEBOUNCE(DEBOUNCE)) u_arrive (
        .clock (clock),
        .clear (clear),
        .raw   (arrive_raw),
        .evt   (arr_evt)
    );

    cntry_car_debounce #(.DEBOUNCE(DEBOUNCE)) u_depart (
        .clock (clock),
        .clear (clear),
        .raw   (depart_raw),
        .evt   (dep_evt)
    );

    // Encoding 3 is not a legal light state; it is handled as RED.
    assign sig_red = (cntry_sig == 2'd0) || (cntry_sig == 2'd3);

    always_ff @(posedge clock) begin
        if (clear) begin
            car_count <= '0;
            overflow  <= 1'b0;
            red_run   <= 1'b0;
        end else begin
            if (dep_evt && sig_red) begin
                red_run <= 1'b1;
            end
            if (arr_evt && !dep_evt) begin
                if (car_count == MAX_COUNT) begin
                    overflow <= 1'b1;
                end else begin
                    car_count <= car_count + 1'b1;
                end
            end
            if (dep_evt && !arr_evt && (car_count != '0)) begin
                car_count <= car_count - 1'b1;
            end
        end
    end

    assign car_on_cntry_rd = (car_count != '0);

endmodule
